sti_dac_gen: RTL and testbench
==============================

// Module: sti_dac_gen
// PURPOSE
//  Parametrised serial transmitter plus byte distributor. Accepts a parallel word and
//  shifts it out as a framed bit stream of 8/16/32/64 bits. Frame order, alignment and
//  fill are selectable per load. Every 8 transmitted bits are re-assembled into a byte and
//  written to one of NUM_BANKS odd/even-interleaved memories. A final flush zero-fills all
//  unwritten locations and raises oem_finish.
// PARAMETERS
//  DATA_W      32  pi_data width; power of 2, 16..64
//  NUM_BANKS   8   output memories; even, power of 2; banks 2k/2k+1 form pair k (odd/even)
//  MEM_ADDR_W  5   per-bank address width
//  ROW_LEN     8   bytes per image row; power of 2; drives the checkerboard parity
// PORTS
//  clk          in   1            clock
//  reset        in   1            synchronous, active-high reset
//  load         in   1            parallel word valid; accepted when pi_ready=1
//  pi_ready     out  1            high in IDLE only
//  pi_data      in   DATA_W       parallel word
//  pi_length    in   2            frame bits L = 8<<pi_length (8,16,32,64)
//  pi_fill      in   1            L>DATA_W only: 1 = data in upper part of frame, 0 = lower
//  pi_msb       in   1            1 = frame sent MSB first, 0 = LSB first
//  pi_low       in   1            L<DATA_W only: 1 = pi_data[L-1:0], 0 = pi_data[2L-1:L]
//  pi_end       in   1            no further words; start zero-fill flush
//  so_data      out  1            serial bit
//  so_valid     out  1            so_data qualifier
//  oem_dataout  out  8            byte to memory
//  oem_addr     out  MEM_ADDR_W   memory address
//  oem_wr       out  NUM_BANKS    one-hot write strobe
//  oem_finish   out  1            all locations written; held high until reset
// BEHAVIOUR
//  Reset: all outputs 0 except pi_ready=1. FSM to IDLE. Byte index g=0.
//  Frame F (L bits): if L<=DATA_W, F is the selected slice; L=DATA_W ignores pi_low.
//    If L>DATA_W, F={pi_data,0} when pi_fill=1, else {0,pi_data}. Captured on load&pi_ready.
//  FSM IDLE->SHIFT on load. SHIFT runs L cycles, one bit per cycle, so_valid=1.
//    First bit appears the cycle after acceptance. Then ->IDLE (or PARITY if enabled).
//  Back-to-back: pi_ready rises the cycle after the last bit. Minimum gap is 1 idle cycle.
//  load while pi_ready=0 is ignored.
//  Byte assembly: bits collected in send order, first bit -> bit7. When the 8th bit is on
//    so_data at cycle t, the byte, oem_addr and one oem_wr bit are driven at t+1 for 1 cycle.
//  Bank map: g width = log2(NUM_BANKS/2)+MEM_ADDR_W+1. pair = g[MSBs]; p = low
//    MEM_ADDR_W+1 bits. row = p/ROW_LEN. chk = p[0]^row[0]. Bank = 2*pair+chk.
//    oem_addr = p[MEM_ADDR_W:1]. g increments per byte and wraps to 0 (overwrite).
//  pi_end: sampled in IDLE (->FLUSH). If raised during SHIFT it is latched and taken at
//    frame end. FLUSH writes 0x00 once per cycle at successive g until g wraps to 0.
//    FLUSH ->DONE: oem_finish=1, pi_ready=0, further load ignored.
//  pi_end with g==0 and nothing written: FLUSH writes the full space (no shortcut).
//  Reset mid-frame/mid-flush: the partial byte is discarded and no write is issued.
// CONFIGURATION
//  STI_DAC_PARITY_EN defined: after the last frame bit, one PARITY cycle sends the even
//    parity of F (so_valid=1). The parity bit is not fed to byte assembly. Frame = L+1 cycles.
//  Undefined: no PARITY state; frame = exactly L cycles.
// STRUCTURE
//  Package sti_dac_pkg: state_e {IDLE,SHIFT,PARITY,FLUSH,DONE}, LEN_8..LEN_64 codes,
//    BYTE_W=8, function frame_bits(len).
//  Sub-module sti_dac_bank_map: g -> {bank one-hot, oem_addr}; purely combinational, reusable.
// TESTING
//  1 pi_data=32'h0000_A5C3, len=01, low=1, msb=1 -> so_data 1010010111000011,
//    writes 0xA5 bank0 addr0 then 0xC3 bank1 addr0
//  2 len=00, low=0, msb=0, data=32'h0000_8100 -> byte 0x81 sent LSB first:
//    bits 1,0,0,0,0,0,0,1; written 0x81
//  3 len=11, fill=1, msb=1, data=32'hFFFF_FFFF -> 32 ones then 32 zeros, 8 writes:
//    4x0xFF then 4x0x00
//  4 load held high across two frames -> exactly two frames accepted, 1-cycle pi_ready
//    gap, g advances by bytes sent
//  5 write ROW_LEN+1 bytes -> byte ROW_LEN lands on the odd bank of the pair
//    (checkerboard flip); pi_end -> zero writes until oem_finish
//  6 reset asserted mid-SHIFT -> next cycle so_valid=0, oem_wr=0, pi_ready=1, g=0;
//    with STI_DAC_PARITY_EN, frame 0x01 (len=00) -> 9th bit=1

Source files
------------

// File: rtl/sti_dac_pkg.sv
// Shared types and helpers for the sti_dac_gen serial transmitter / byte distributor.
package sti_dac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StParity,
    StFlush,
    StDone
  } state_e;

  // pi_length codes
  localparam logic [1:0] Len8  = 2'd0;
  localparam logic [1:0] Len16 = 2'd1;
  localparam logic [1:0] Len32 = 2'd2;
  localparam logic [1:0] Len64 = 2'd3;

  localparam int unsigned ByteW     = 8;
  localparam int unsigned MaxFrameW = 64;

  // Frame length in bits for a pi_length code.
  function automatic int unsigned frame_bits(logic [1:0] len);
    int unsigned bits;
    case (len)
      Len8:    bits = 8;
      Len16:   bits = 16;
      Len32:   bits = 32;
      Len64:   bits = 64;
      default: bits = 8;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/sti_dac_bank_map.sv
// Byte index -> memory bank strobe and address. Consecutive bytes alternate between the two
// banks of a pair, and the alternation flips every ROW_LEN bytes (checkerboard). Combinational.
module sti_dac_bank_map #(
  parameter int unsigned NUM_BANKS  = 8,
  parameter int unsigned MEM_ADDR_W = 5,
  parameter int unsigned ROW_LEN    = 8,
  localparam int unsigned GW = $clog2(NUM_BANKS / 2) + MEM_ADDR_W + 1
) (
  input  logic [GW-1:0]         g,
  output logic [NUM_BANKS-1:0]  bank_oh,
  output logic [MEM_ADDR_W-1:0] addr
);

  localparam int unsigned BankW = $clog2(NUM_BANKS);
  localparam int unsigned RowSh = $clog2(ROW_LEN);

  logic             chk;
  logic [BankW-1:0] bank_idx;

  // Pair from the top bits, odd/even bank from position parity xor row parity.
  always_comb begin
    chk      = g[0] ^ (|((g[MEM_ADDR_W:0] >> RowSh) & (MEM_ADDR_W + 1)'(1)));
    bank_idx = BankW'({g >> (MEM_ADDR_W + 1), chk});
    bank_oh  = NUM_BANKS'(1) << bank_idx;
    addr     = g[MEM_ADDR_W:1];
  end

endmodule

// File: rtl/sti_dac_gen.sv
// Serial frame transmitter plus byte distributor. Each accepted word is framed to 8/16/32/64
// bits and shifted out one bit per cycle; every 8 sent bits become one memory byte written to
// an odd/even interleaved bank. pi_end zero-fills the remaining locations and raises
// oem_finish. Optional feature macro: STI_DAC_PARITY_EN appends an even-parity bit per frame.
module sti_dac_gen
  import sti_dac_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_BANKS  = 8,
  parameter int unsigned MEM_ADDR_W = 5,
  parameter int unsigned ROW_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  output logic                  pi_ready,
  input  logic [DATA_W-1:0]     pi_data,
  input  logic [1:0]            pi_length,
  input  logic                  pi_fill,
  input  logic                  pi_msb,
  input  logic                  pi_low,
  input  logic                  pi_end,
  output logic                  so_data,
  output logic                  so_valid,
  output logic [ByteW-1:0]      oem_dataout,
  output logic [MEM_ADDR_W-1:0] oem_addr,
  output logic [NUM_BANKS-1:0]  oem_wr,
  output logic                  oem_finish
);

  localparam int unsigned GW = $clog2(NUM_BANKS / 2) + MEM_ADDR_W + 1;
  localparam int unsigned FW = MaxFrameW;

  state_e            state_q, state_d;
  logic [FW-1:0]     sh_q, sh_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [1:0]        len_q, len_d;
  logic              msb_q, msb_d;
  logic              end_q, end_d;
  logic [ByteW-2:0]  byte_q, byte_d;
  logic [GW-1:0]     g_q, g_d;
  logic              wr_q, wr_d;
  logic [GW-1:0]     wr_g_q, wr_g_d;
  logic [ByteW-1:0]  dout_q, dout_d;
`ifdef STI_DAC_PARITY_EN
  logic              par_q, par_d;
`endif

  int unsigned       len_bits;
  logic [FW-1:0]     data_ext, mask, frame_c;
  logic              cur_bit, last_bit;
  logic [NUM_BANKS-1:0] map_oh;

  // Build the frame from the incoming word: slice when shorter, pad when longer.
  always_comb begin
    len_bits = frame_bits(pi_length);
    data_ext = FW'(pi_data);
    mask     = (len_bits >= FW) ? '1 : ((FW'(1) << len_bits) - FW'(1));
    if (len_bits < DATA_W) begin
      frame_c = (pi_low ? data_ext : (data_ext >> len_bits)) & mask;
    end else if (len_bits == DATA_W) begin
      frame_c = data_ext;
    end else if (pi_fill) begin
      frame_c = data_ext << (len_bits - DATA_W);
    end else begin
      frame_c = data_ext;
    end
  end

  // MSB-first frames are left-justified so both directions shift from a fixed end.
  assign cur_bit  = msb_q ? sh_q[FW-1] : sh_q[0];
  assign last_bit = (cnt_q == 7'(frame_bits(len_q) - 1));

  // Next-state, serial outputs and byte-write scheduling.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    msb_d      = msb_q;
    end_d      = end_q;
    byte_d     = byte_q;
    g_d        = g_q;
    wr_d       = 1'b0;
    wr_g_d     = wr_g_q;
    dout_d     = dout_q;
`ifdef STI_DAC_PARITY_EN
    par_d      = par_q;
`endif
    so_data    = 1'b0;
    so_valid   = 1'b0;
    pi_ready   = 1'b0;
    oem_finish = 1'b0;

    case (state_q)
      StIdle: begin
        pi_ready = 1'b1;
        if (pi_end) begin
          state_d = StFlush;
        end else if (load) begin
          state_d = StShift;
          sh_d    = pi_msb ? (frame_c << (FW - len_bits)) : frame_c;
          cnt_d   = '0;
          len_d   = pi_length;
          msb_d   = pi_msb;
          end_d   = 1'b0;
`ifdef STI_DAC_PARITY_EN
          par_d   = ^frame_c;
`endif
        end
      end
      StShift: begin
        so_valid = 1'b1;
        so_data  = cur_bit;
        sh_d     = msb_q ? (sh_q << 1) : (sh_q >> 1);
        cnt_d    = cnt_q + 7'd1;
        byte_d   = {byte_q[ByteW-3:0], cur_bit};
        if (pi_end) end_d = 1'b1;
        // Frames are whole bytes, so the low count bits locate the 8th bit of each byte.
        if (cnt_q[2:0] == 3'd7) begin
          wr_d   = 1'b1;
          wr_g_d = g_q;
          dout_d = {byte_q, cur_bit};
          g_d    = g_q + GW'(1);
        end
        if (last_bit) begin
`ifdef STI_DAC_PARITY_EN
          state_d = StParity;
`else
          state_d = end_d ? StFlush : StIdle;
`endif
        end
      end
`ifdef STI_DAC_PARITY_EN
      StParity: begin
        so_valid = 1'b1;
        so_data  = par_q;
        if (pi_end) end_d = 1'b1;
        state_d = end_d ? StFlush : StIdle;
      end
`endif
      StFlush: begin
        wr_d   = 1'b1;
        wr_g_d = g_q;
        dout_d = '0;
        g_d    = g_q + GW'(1);
        if (g_q == '1) state_d = StDone;
      end
      StDone: begin
        oem_finish = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any partial byte and pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      msb_q   <= 1'b0;
      end_q   <= 1'b0;
      byte_q  <= '0;
      g_q     <= '0;
      wr_q    <= 1'b0;
      wr_g_q  <= '0;
      dout_q  <= '0;
`ifdef STI_DAC_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      msb_q   <= msb_d;
      end_q   <= end_d;
      byte_q  <= byte_d;
      g_q     <= g_d;
      wr_q    <= wr_d;
      wr_g_q  <= wr_g_d;
      dout_q  <= dout_d;
`ifdef STI_DAC_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  sti_dac_bank_map #(
    .NUM_BANKS  (NUM_BANKS),
    .MEM_ADDR_W (MEM_ADDR_W),
    .ROW_LEN    (ROW_LEN)
  ) u_bank_map (
    .g       (wr_g_q),
    .bank_oh (map_oh),
    .addr    (oem_addr)
  );

  assign oem_dataout = dout_q;
  assign oem_wr      = wr_q ? map_oh : '0;

endmodule

// File: tb/tb_sti_dac_gen.sv
`timescale 1ns/1ps
module tb_sti_dac_gen;

  localparam int DW  = 32;
  localparam int NB  = 8;
  localparam int MAW = 5;
  localparam int RL  = 8;
  localparam int PS  = 1 << (MAW + 1);
  localparam int NG  = (NB / 2) * PS;
`ifdef STI_DAC_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic          pi_ready;
  logic [DW-1:0] pi_data = '0;
  logic [1:0]    pi_length = '0;
  logic          pi_fill = 1'b0, pi_msb = 1'b0, pi_low = 1'b0, pi_end = 1'b0;
  logic          so_data, so_valid;
  logic [7:0]    oem_dataout;
  logic [MAW-1:0] oem_addr;
  logic [NB-1:0] oem_wr;
  logic          oem_finish;

  sti_dac_gen #(
    .DATA_W     (DW),
    .NUM_BANKS  (NB),
    .MEM_ADDR_W (MAW),
    .ROW_LEN    (RL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .pi_ready    (pi_ready),
    .pi_data     (pi_data),
    .pi_length   (pi_length),
    .pi_fill     (pi_fill),
    .pi_msb      (pi_msb),
    .pi_low      (pi_low),
    .pi_end      (pi_end),
    .so_data     (so_data),
    .so_valid    (so_valid),
    .oem_dataout (oem_dataout),
    .oem_addr    (oem_addr),
    .oem_wr      (oem_wr),
    .oem_finish  (oem_finish)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          exp_bits[$];
  logic [23:0] exp_w[$];
  int          m_busy = 0, m_flush = 0, m_g = 0, m_sent = 0;
  bit          m_done = 0, m_end = 0, m_wr_now = 0;

  function automatic logic [63:0] make_frame(logic [31:0] d, logic [1:0] len, bit fill, bit low);
    int l;
    logic [63:0] d64, m;
    l   = 8 << len;
    d64 = {32'b0, d};
    m   = (l == 64) ? '1 : ((64'd1 << l) - 64'd1);
    if (l < DW) return low ? (d64 & m) : ((d64 >> l) & m);
    else if (l == DW) return d64;
    else return fill ? (d64 << (l - DW)) : d64;
  endfunction

  function automatic logic [23:0] exp_write(int g, logic [7:0] d);
    int p, pair, bank;
    logic [7:0] oh;
    p    = g % PS;
    pair = g / PS;
    bank = 2 * pair + ((p % 2) ^ ((p / RL) % 2));
    oh   = 8'(1) << bank;
    return {oh, 8'(p / 2), d};
  endfunction

  function automatic bit m_ready();
    return (m_busy == 0) && (m_flush == 0) && !m_done;
  endfunction

  task automatic m_start_flush();
    m_flush = NG - m_g;
    for (int i = m_g; i < NG; i++) exp_w.push_back(exp_write(i, 8'h00));
    m_g   = 0;
    m_end = 0;
  endtask

  task automatic m_accept();
    logic [63:0] f;
    logic [7:0]  acc;
    bit          b;
    int          l;
    f   = make_frame(pi_data, pi_length, pi_fill, pi_low);
    l   = 8 << pi_length;
    acc = '0;
    for (int k = 0; k < l; k++) begin
      b = pi_msb ? f[l-1-k] : f[k];
      exp_bits.push_back(b);
      acc = {acc[6:0], b};
      if (k % 8 == 7) begin
        exp_w.push_back(exp_write(m_g, acc));
        m_g = (m_g + 1) % NG;
      end
    end
    if (PAR != 0) exp_bits.push_back(^f);
    m_busy = l + PAR;
    m_sent = 0;
    m_end  = 0;
  endtask

  initial forever begin
    @(posedge clk);
    m_wr_now = 0;
    if (reset) begin
      exp_bits.delete();
      exp_w.delete();
      m_busy = 0; m_flush = 0; m_g = 0; m_done = 0; m_end = 0;
    end else if (m_busy > 0) begin
      if (m_busy > PAR) begin
        m_sent++;
        if (m_sent % 8 == 0) m_wr_now = 1;
      end
      if (pi_end) m_end = 1;
      m_busy--;
      if (m_busy == 0 && m_end) m_start_flush();
    end else if (m_flush > 0) begin
      m_flush--;
      m_wr_now = 1;
      if (m_flush == 0) m_done = 1;
    end else if (!m_done) begin
      if (pi_end) m_start_flush();
      else if (load) m_accept();
    end
  end

  // ---------------- monitor ----------------
  bit          mon_en = 0;
  logic [63:0] cap = '0;
  logic [23:0] wlog[$];
  logic [23:0] wpack;
  int          sv_cnt = 0, pend_gap = 0, gap = -1;
  bit          sv_seen = 0;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("pi_ready", pi_ready, m_ready());
      check("oem_finish", oem_finish, m_done);
      check("so_valid", so_valid, m_busy > 0);
      if (m_busy > 0 && exp_bits.size() > 0) check("so_data", so_data, exp_bits.pop_front());
      if (so_valid) begin
        cap = {cap[62:0], so_data};
        sv_cnt++;
        if (sv_seen && pend_gap > 0) gap = pend_gap;
        pend_gap = 0;
        sv_seen  = 1;
      end else if (sv_seen) begin
        pend_gap++;
      end
      check("wr_timing", |oem_wr, m_wr_now);
      if (|oem_wr) begin
        wpack = {8'(oem_wr), 8'(oem_addr), oem_dataout};
        wlog.push_back(wpack);
        if (exp_w.size() == 0) check("wr_extra", 1, 0);
        else check("wr", wpack, exp_w.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!pi_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!pi_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send(logic [31:0] d, logic [1:0] len, bit fill, bit msb, bit low);
    wait_ready();
    pi_data = d; pi_length = len; pi_fill = fill; pi_msb = msb; pi_low = low;
    load = 1'b1;
    @(posedge clk);
    #2 load = 1'b0;
  endtask

  task automatic wait_finish();
    int n;
    n = 0;
    while (!oem_finish && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("finish", oem_finish, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    mon_en = 1;
    @(negedge clk);
    check("rst_ready", pi_ready, 1);
    check("rst_valid", so_valid, 0);
    check("rst_wr", oem_wr, 0);
    check("rst_out", {oem_dataout, 3'b0, oem_addr, oem_finish, so_data}, 0);
    reset = 1'b0;

    // 1: 16-bit low slice, MSB first
    wlog.delete(); cap = '0;
    send(32'h0000_A5C3, 2'b01, 0, 1, 1);
    idle(24);
    check("t1_stream", (cap >> PAR) & 64'hFFFF, 64'hA5C3);
    check("t1_nwr", wlog.size(), 2);
    if (wlog.size() >= 2) check("t1_wr", {wlog[0], wlog[1]}, 48'h0100A5_0200C3);

    // 2: 8-bit upper slice, LSB first
    wlog.delete(); cap = '0;
    send(32'h0000_8100, 2'b00, 0, 0, 0);
    idle(14);
    check("t2_stream", (cap >> PAR) & 64'hFF, 64'h81);
    if (wlog.size() >= 1) check("t2_byte", wlog[0][7:0], 8'h81);
    else check("t2_nwr", wlog.size(), 1);

    // 3: 64-bit frame, data in upper half
    wlog.delete();
    send(32'hFFFF_FFFF, 2'b11, 1, 1, 0);
    idle(72);
    check("t3_nwr", wlog.size(), 8);
    if (wlog.size() >= 8)
      check("t3_bytes", {wlog[0][7:0], wlog[1][7:0], wlog[2][7:0], wlog[3][7:0],
                         wlog[4][7:0], wlog[5][7:0], wlog[6][7:0], wlog[7][7:0]},
            64'hFFFF_FFFF_0000_0000);

    // 4: load held across two frames
    wait_ready();
    sv_cnt = 0; sv_seen = 0; pend_gap = 0; gap = -1;
    pi_data = 32'h0000_005A; pi_length = 2'b00; pi_fill = 0; pi_msb = 1; pi_low = 1;
    load = 1'b1;
    repeat (8 + 2 + PAR) @(posedge clk);
    #2 load = 1'b0;
    idle(30);
    check("t4_valid_cycles", sv_cnt, 2 * (8 + PAR));
    check("t4_gap", gap, 1);

    // 6: reset mid-shift
    send(32'h1234_5678, 2'b10, 0, 1, 1);
    idle(5);
    reset = 1'b1;
    @(negedge clk);
    check("t6_valid", so_valid, 0);
    check("t6_wr", oem_wr, 0);
    check("t6_ready", pi_ready, 1);
    reset = 1'b0;
    wlog.delete();
    send(32'h0000_003C, 2'b00, 0, 1, 1);
    idle(14);
    check("t6_nwr", wlog.size(), 1);
    if (wlog.size() >= 1) check("t6_g0", wlog[0], 24'h01003C);
`ifdef STI_DAC_PARITY_EN
    cap = '0;
    send(32'h0000_0001, 2'b00, 0, 1, 1);
    idle(14);
    check("t6_parity", cap & 64'h1FF, 64'h003);
`endif

    // 5: checkerboard flip then flush
    do_reset();
    wlog.delete();
    send(32'hDEAD_BEEF, 2'b11, 0, 1, 0);
    send(32'h0000_00C7, 2'b00, 0, 1, 1);
    idle(14);
    check("t5_nwr", wlog.size(), RL + 1);
    if (wlog.size() >= RL + 1) check("t5_flip", wlog[RL][23:8], 16'h0204);
    pi_end = 1'b1;
    @(negedge clk);
    pi_end = 1'b0;
    wait_finish();
    idle(2);
    check("t5_total_wr", wlog.size(), NG);
    check("t5_exp_left", exp_w.size(), 0);
    pi_data = 32'h0000_00FF; load = 1'b1;
    idle(5);
    load = 1'b0;
    check("t5_done_ready", pi_ready, 0);

    // random frames, then pi_end raised mid-frame
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    send($urandom, 2'b11, 0, 1, 0);
    idle(10);
    pi_end = 1'b1;
    @(negedge clk);
    pi_end = 1'b0;
    wait_finish();
    idle(3);
    check("rand_exp_left", exp_w.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
